// File: rtl/seq_alu_mac.sv
// Handshaked sequential ALU with a shift-add multiplier and a persistent MAC accumulator.
// One operation in flight at a time: IDLE accepts a beat, MULT iterates, HOLD presents the result.
module seq_alu_mac #(
  parameter int NBITS = 16,
  parameter int ACCW  = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACCW-1:0]  y,
  output logic             co
);

  generate
    if (ACCW < 2 * NBITS) begin : g_bad_accw
      $error("seq_alu_mac: ACCW must be >= 2*NBITS");
    end
    if (NBITS < 2) begin : g_bad_nbits
      $error("seq_alu_mac: NBITS must be >= 2");
    end
  endgenerate

  localparam int PW   = 2 * NBITS;
  localparam int CNTW = $clog2(NBITS);

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_AND    = 3'b010;
  localparam logic [2:0] OP_OR     = 3'b011;
  localparam logic [2:0] OP_XOR    = 3'b100;
  localparam logic [2:0] OP_MUL    = 3'b101;
  localparam logic [2:0] OP_MAC    = 3'b110;
  localparam logic [2:0] OP_CLRACC = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       r_state;
  logic [2:0]       r_op;
  logic [ACCW-1:0]  r_acc;
  logic [ACCW-1:0]  r_y;
  logic             r_co;
  logic [PW-1:0]    r_mcand;
  logic [NBITS-1:0] r_mplier;
  logic [PW-1:0]    r_prod;
  logic [CNTW-1:0]  r_cnt;

  logic [NBITS:0]   w_add;
  logic [NBITS:0]   w_sub;
  logic [ACCW-1:0]  w_y1;
  logic             w_co1;
  logic [PW-1:0]    w_prod_next;
  logic [ACCW:0]    w_mac;
  logic             w_last;
  logic             w_is_mult_op;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_HOLD);
  assign y         = r_y;
  assign co        = r_co;

  assign w_add = {1'b0, a} + {1'b0, b};
  // Bit NBITS of the widened difference is the borrow, i.e. a < b.
  assign w_sub = {1'b0, a} - {1'b0, b};

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    w_y1  = '0;
    w_co1 = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_y1  = ACCW'(w_add);
        w_co1 = w_add[NBITS];
      end
      OP_SUB: begin
        w_y1  = ACCW'(w_sub[NBITS-1:0]);
        w_co1 = w_sub[NBITS];
      end
      OP_AND:  w_y1 = ACCW'(a & b);
      OP_OR:   w_y1 = ACCW'(a | b);
      OP_XOR:  w_y1 = ACCW'(a ^ b);
      default: w_y1 = '0;
    endcase
  end

  assign w_is_mult_op = (opcode == OP_MUL) || (opcode == OP_MAC);

  // The final shift-add step is folded into the result write so MULT lasts exactly NBITS cycles.
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_mac       = {1'b0, r_acc} + (ACCW + 1)'(w_prod_next);
  assign w_last      = (r_cnt == CNTW'(NBITS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= OP_ADD;
      r_acc    <= '0;
      r_y      <= '0;
      r_co     <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_is_mult_op) begin
              r_op     <= opcode;
              r_mcand  <= PW'(a);
              r_mplier <= b;
              r_prod   <= '0;
              r_cnt    <= '0;
              r_state  <= S_MULT;
            end else begin
              r_y     <= w_y1;
              r_co    <= w_co1;
              if (opcode == OP_CLRACC) begin
                r_acc <= '0;
              end
              r_state <= S_HOLD;
            end
          end
        end
        S_MULT: begin
          r_prod   <= w_prod_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNTW'(1);
          if (w_last) begin
            if (r_op == OP_MAC) begin
              r_acc <= w_mac[ACCW-1:0];
              r_y   <= w_mac[ACCW-1:0];
              r_co  <= w_mac[ACCW];
            end else begin
              r_y   <= ACCW'(w_prod_next);
              r_co  <= 1'b0;
            end
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_mac.sv
// Self-checking bench for seq_alu_mac: an ACCW=40 and an ACCW=32 instance share clock and reset,
// and every result is compared with an arithmetic reference model of the opcode rules.
module tb_seq_alu_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv   [2];
  logic        ir   [2];
  logic        ov   [2];
  logic        ordy [2];
  logic        co_s [2];
  logic [15:0] a_s  [2];
  logic [15:0] b_s  [2];
  logic [2:0]  op_s [2];
  logic [39:0] y40;
  logic [31:0] y32;

  longint unsigned macc [2];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_alu_mac #(.NBITS(16), .ACCW(40)) dut (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_s[0]), .b(b_s[0]),
    .opcode(op_s[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .y(y40), .co(co_s[0])
  );

  seq_alu_mac #(.NBITS(16), .ACCW(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_s[1]), .b(b_s[1]),
    .opcode(op_s[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .y(y32), .co(co_s[1])
  );

  // Reference model: plain 64-bit arithmetic straight from the opcode table.
  function automatic void model(input bit sel, input logic [2:0] op, input logic [15:0] ma,
                                input logic [15:0] mb, output logic [63:0] ey, output logic ec);
    longint unsigned ua   = ma;
    longint unsigned ub   = mb;
    int              accw = sel ? 32 : 40;
    longint unsigned mask = (64'd1 << accw) - 1;
    longint unsigned s;
    ec = 1'b0;
    ey = '0;
    case (op)
      3'd0: begin s = ua + ub; ey = s; ec = s[16]; end
      3'd1: begin ey = (ua + 65536 - ub) & 64'hFFFF; ec = (ua < ub); end
      3'd2: ey = ua & ub;
      3'd3: ey = ua | ub;
      3'd4: ey = ua ^ ub;
      3'd5: ey = ua * ub;
      3'd6: begin
        s = macc[sel] + ua * ub;
        ec = ((s >> accw) & 1) != 0;
        macc[sel] = s & mask;
        ey = macc[sel];
      end
      default: macc[sel] = 0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
    return (op == 3'd5 || op == 3'd6) ? 17 : 1;
  endfunction

  // Drives one beat (called at a negedge), waits for the result, applies bp cycles of
  // backpressure, releases it and reports what was observed.
  task automatic run_op(input bit sel, input logic [2:0] op, input logic [15:0] oa,
                        input logic [15:0] ob, input int bp, input bit pulse,
                        output logic [63:0] ry, output logic rco, output int lat,
                        output bit busy_rdy, output bit unstable, output bit bad_rel,
                        output bit timeout, output realtime t_acc);
    int w = 0;
    busy_rdy = 0; unstable = 0; bad_rel = 0; timeout = 0; lat = 0; ry = '0; rco = 1'b0;
    while (!ir[sel] && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!ir[sel]) timeout = 1;
    a_s[sel] = oa; b_s[sel] = ob; op_s[sel] = op; iv[sel] = 1'b1;
    @(posedge clk);
    t_acc = $realtime;
    #1;
    iv[sel] = 1'b0;
    a_s[sel] = 16'($urandom); b_s[sel] = 16'($urandom); op_s[sel] = 3'($urandom);
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (ov[sel]) break;
      if (ir[sel]) busy_rdy = 1;
      if (pulse) iv[sel] = 1'($urandom_range(0, 1));
    end
    iv[sel] = 1'b0;
    if (!ov[sel]) begin
      timeout = 1;
      return;
    end
    if (ir[sel]) busy_rdy = 1;
    ry  = sel ? {32'd0, y32} : {24'd0, y40};
    rco = co_s[sel];
    if (bp > 0) begin
      ordy[sel] = 1'b0;
      repeat (bp) begin
        @(negedge clk);
        if (!ov[sel] || rco !== co_s[sel] || ry !== (sel ? {32'd0, y32} : {24'd0, y40}))
          unstable = 1;
        if (ir[sel]) busy_rdy = 1;
      end
      ordy[sel] = 1'b1;
    end
    @(negedge clk);
    if (ov[sel] || !ir[sel]) bad_rel = 1;
  endtask

  // Runs one op, checks it against the model and bumps the counters.
  task automatic exec(input string name, input bit sel, input logic [2:0] op,
                      input logic [15:0] oa, input logic [15:0] ob, input int bp,
                      input bit pulse, output realtime t_acc);
    logic [63:0] ry, ey;
    logic        rco, ec;
    int          lat;
    bit          busy_rdy, unstable, bad_rel, timeout;
    model(sel, op, oa, ob, ey, ec);
    run_op(sel, op, oa, ob, bp, pulse, ry, rco, lat, busy_rdy, unstable, bad_rel, timeout, t_acc);
    total++;
    if (timeout) begin
      bad++;
      $display("FAIL %s timeout: no handshake within 100 cycles", name);
    end
    total++;
    if (ry !== ey || rco !== ec) begin
      bad++;
      $display("FAIL %s result: got y=%0h co=%b, want y=%0h co=%b", name, ry, rco, ey, ec);
    end
    total++;
    if (lat !== exp_lat(op)) begin
      bad++;
      $display("FAIL %s latency: got %0d, want %0d", name, lat, exp_lat(op));
    end
    total++;
    if (busy_rdy || unstable || bad_rel) begin
      bad++;
      $display("FAIL %s handshake: in_ready_while_busy=%0d unstable=%0d bad_release=%0d, want 0/0/0",
               name, busy_rdy, unstable, bad_rel);
    end
  endtask

  task automatic test_reset();
    total++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || y40 !== 40'd0 || co_s[0] !== 1'b0 ||
        ir[1] !== 1'b1 || ov[1] !== 1'b0 || y32 !== 32'd0 || co_s[1] !== 1'b0) begin
      bad++;
      $display("FAIL reset: in_ready=%b/%b out_valid=%b/%b y=%0h/%0h co=%b/%b, want 1/1 0/0 0/0 0/0",
               ir[0], ir[1], ov[0], ov[1], y40, y32, co_s[0], co_s[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    macc[0] = 0;
    macc[1] = 0;
  endtask

  task automatic test_basic();
    realtime t;
    exec("add_10_5", 0, 3'd0, 16'd10, 16'd5, 0, 0, t);
    exec("sub_20_30", 0, 3'd1, 16'd20, 16'd30, 0, 0, t);
    exec("add_carry", 0, 3'd0, 16'hFFFF, 16'h0001, 0, 0, t);
    exec("xor", 0, 3'd4, 16'hF0F0, 16'hFF00, 0, 0, t);
    exec("and", 0, 3'd2, 16'hF0F0, 16'hFF00, 1, 0, t);
    exec("or", 0, 3'd3, 16'hF0F0, 16'h0F01, 0, 0, t);
    exec("sub_equal", 0, 3'd1, 16'h1234, 16'h1234, 0, 0, t);
  endtask

  task automatic test_mul();
    realtime t;
    exec("mul_max", 0, 3'd5, 16'hFFFF, 16'hFFFF, 0, 1, t);
    exec("mul_zero", 0, 3'd5, 16'h0000, 16'hBEEF, 0, 1, t);
  endtask

  task automatic test_mac();
    realtime t;
    exec("clracc", 0, 3'd7, 16'h1111, 16'h2222, 0, 0, t);
    exec("mac_3x4", 0, 3'd6, 16'd3, 16'd4, 0, 0, t);
    exec("mac_5x6_bp", 0, 3'd6, 16'd5, 16'd6, 5, 0, t);
  endtask

  task automatic test_mac_wrap32();
    realtime t;
    exec("w32_clracc", 1, 3'd7, 16'd0, 16'd0, 0, 0, t);
    exec("w32_mac1", 1, 3'd6, 16'hFFFF, 16'hFFFF, 0, 0, t);
    exec("w32_mac2", 1, 3'd6, 16'hFFFF, 16'hFFFF, 0, 0, t);
  endtask

  task automatic test_back_to_back();
    realtime t1, t2;
    exec("b2b_first", 0, 3'd0, 16'd1, 16'd2, 0, 0, t1);
    exec("b2b_second", 0, 3'd1, 16'd7, 16'd3, 0, 0, t2);
    total++;
    if (t2 - t1 != 20.0) begin
      bad++;
      $display("FAIL b2b_spacing: accepts %0t apart, want 20", t2 - t1);
    end
  endtask

  task automatic test_reset_abort();
    realtime t;
    bit      saw_valid = 0;
    exec("abort_clr", 0, 3'd7, 16'd0, 16'd0, 0, 0, t);
    exec("abort_mac_7x7", 0, 3'd6, 16'd7, 16'd7, 0, 0, t);
    a_s[0] = 16'd9; b_s[0] = 16'd9; op_s[0] = 3'd6; iv[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    repeat (7) begin
      @(posedge clk);
      if (ov[0]) saw_valid = 1;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || y40 !== 40'd0 || co_s[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_async: out_valid=%b in_ready=%b y=%0h co=%b, want 0 1 0 0",
               ov[0], ir[0], y40, co_s[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    macc[0] = 0;
    macc[1] = 0;
    repeat (20) begin
      @(negedge clk);
      if (ov[0] || !ir[0]) saw_valid = 1;
    end
    total++;
    if (saw_valid) begin
      bad++;
      $display("FAIL abort_quiet: out_valid or busy seen for aborted op, want none");
    end
    exec("abort_mac_2x2", 0, 3'd6, 16'd2, 16'd2, 0, 0, t);
  endtask

  task automatic test_random();
    realtime t;
    for (int i = 0; i < 40; i++) begin
      exec("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
           16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), t);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; a_s[i] = '0; b_s[i] = '0; op_s[i] = '0; macc[i] = 0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_mul();
    test_mac();
    test_mac_wrap32();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
